execute_stage: RTL and testbench
================================

# execute_stage

Execute stage of the 16-bit pipelined core. It consumes the operand and control outputs of the decode/execute pipeline register. It performs operand forwarding, ALU operations and write-address selection, and holds the architectural HI/LO registers. Multiply and divide run on an iterative 16-step unit, and the stage stalls the front of the pipeline while that unit is busy. Its outputs feed the execute/memory pipeline register.

## Interface
- No parameters; datapath width fixed at 16 bits.
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- Erd1, Erd2  in  16  register-file read data
- Esignextimm  in  16  sign-extended immediate
- Ea2, Ea3  in  4  candidate RF write addresses
- Ealucontrol  in  5  operation select
- Ealusrc  in  1  srcb select: 0 = forwarded Erd2, 1 = Esignextimm
- Eregwrite  in  2  write-address select: 00 = Ea2, 01 = Ea3, 10 = 4'd15, 11 = 4'd0
- Ehilowrite  in  1  HI/LO write enable
- Emultdiv  in  1  HI/LO source: 1 = mul/div unit, 0 = move-to (HI <= srca, LO <= srcb)
- Emod  in  1  on DIV/DIVU, 1 puts the remainder on Ealuout; 0 puts the quotient
- Eforwarda, Eforwardb  in  2  operand source: 00 = Erd, 01 = Wresult, 10 = Mresult, 11 = Erd
- Mresult, Wresult  in  16  forwarded results from memory and writeback stages
- Ealuout  out  16  result
- Ewritedata  out  16  forwarded Erd2, used as store data
- Ewriteaddr  out  4  selected RF write address
- Ezero  out  1  Ealuout == 0
- Ehi, Elo  out  16  HI/LO register contents
- Estall  out  1  hold the fetch, decode and D/E registers this cycle

## Operation
- srca = forward mux(Eforwarda). srcb = Ealusrc ? Esignextimm : forward mux(Eforwardb).
- Single-cycle ops, all combinational:
  - 00000 ADD, 00001 SUB, both modulo 2^16
  - 00010 AND, 00011 OR, 00100 XOR, 00101 NOR
  - 00110 SLT: signed, result 1/0
  - 00111 SLL, 01000 SRL, 01001 SRA: shift amount srcb[3:0]
  - 01010 PASSB: result = srcb
  - 10100 MFHI, 10101 MFLO: result = Ehi / Elo
  - All unlisted codes give result 0.
- Multi-cycle ops:
  - 10000 MULT: signed, exact 32-bit two's-complement product; HI = [31:16], LO = [15:0]; Ealuout = LO at DONE.
  - 10001 MULTU: as MULT, unsigned.
  - 10010 DIV: signed, truncating; remainder takes the sign of the dividend.
  - 10011 DIVU: unsigned.
  - For DIV/DIVU, LO = quotient, HI = remainder.
- Divide boundary cases:
  - Divisor 0: quotient 0xFFFF, remainder srca. No trap.
  - 0x8000 / 0xFFFF signed: quotient 0x8000, remainder 0.
- Mul/div FSM, three states:
  - IDLE: if Ealucontrol is a mul/div op, assert Estall combinationally, latch srca, srcb and the op, clear the step counter, then go to BUSY. Otherwise stay in IDLE with Estall = 0.
  - BUSY: Estall = 1. Perform one shift-add or restoring-divide step per cycle. After the 16th step, go to DONE.
  - DONE: Estall = 0. The result is valid on Ealuout. The instruction leaves E at the end of this cycle. Go to IDLE unconditionally; this prevents re-issue of the held instruction.
- The unit uses only the latched operands. Forwarding-input changes during BUSY have no effect.
- HI/LO update:
  - Ehilowrite with Emultdiv = 1 and a mul/div op: HI/LO are written at the clock edge ending DONE.
  - Ehilowrite with Emultdiv = 0: HI/LO are written at the end of that cycle. This is never stalled.
  - Ehilowrite with Emultdiv = 1 and a non-mul/div op: no write.
- Ewritedata, Ewriteaddr and Ezero are combinational. Ewe3, Ewe and Eregdata are not used here; the E/M register takes them directly from the D/E register.

## Timing
- Single-cycle ops: zero latency, combinational through to the E/M register.
- Mul/div with the op first presented in cycle 0:
  - Estall is high in cycles 0–16.
  - DONE is cycle 17, with Estall low and Ealuout valid.
  - HI/LO reflect the new values from cycle 18.
  - Occupancy is 18 cycles.
- Back-to-back mul/div: the second op's cycle 0 is the cycle right after the first op's DONE.
- MFHI/MFLO directly after a mul/div reads the updated HI/LO; no extra hazard handling is needed.
- Reset values:
  - FSM goes to IDLE; Ehi = Elo = 0x0000.
  - Estall = 0 in the cycle after reset is sampled, if the presented op is not mul/div.
  - Combinational outputs follow their inputs.
- Reset asserted mid-BUSY: the operation is aborted and HI/LO are cleared. No partial result is written.

## Test plan
- ADD: srca 0x7FFF, srcb 0x0001 → Ealuout 0x8000, Ezero 0. SLT: 0x8000 vs 0x0001 → 0x0001. SRA: 0x8000 by 3 → 0xF000.
- MULT: 0xFFFE × 0x0003 → Estall high 17 cycles; Ealuout 0xFFFA in DONE; then Ehi 0xFFFF, Elo 0xFFFA.
- DIVU 100 / 7:
  - Emod 0 → Ealuout 0x000E.
  - Emod 1 → Ealuout 0x0002.
  - Both cases: Elo 0x000E, Ehi 0x0002.
- DIV boundary cases:
  - 0x1234 / 0 → Elo 0xFFFF, Ehi 0x1234.
  - 0x8000 / 0xFFFF → Elo 0x8000, Ehi 0x0000.
  - −7 / 2 → Elo 0xFFFD, Ehi 0xFFFF.
- MULTU 0xFFFF × 0xFFFF immediately followed by DIVU:
  - MULTU result: Ehi 0xFFFE, Elo 0x0001.
  - DIVU enters IDLE→BUSY the cycle after DONE.
  - Then assert reset in BUSY step 5 → next cycle Estall 0, Ehi = Elo = 0.
- Forwarding and write address:
  - Eforwarda 10, Mresult 0x0010, Ealusrc 1, imm 0x0005, ADD → 0x0015.
  - Eregwrite 10 → Ewriteaddr 15.
  - Change Mresult during a MULT BUSY → the product is unchanged.

Source files
------------

// File: rtl/execute_if.sv
// Bundles the decode/execute register outputs and the execute-stage results.
// master drives the stage operands and controls; slave is the execute stage.
interface execute_if;
    logic [15:0] Erd1;
    logic [15:0] Erd2;
    logic [15:0] Esignextimm;
    logic [3:0]  Ea2;
    logic [3:0]  Ea3;
    logic [4:0]  Ealucontrol;
    logic        Ealusrc;
    logic [1:0]  Eregwrite;
    logic        Ehilowrite;
    logic        Emultdiv;
    logic        Emod;
    logic [1:0]  Eforwarda;
    logic [1:0]  Eforwardb;
    logic [15:0] Mresult;
    logic [15:0] Wresult;
    logic [15:0] Ealuout;
    logic [15:0] Ewritedata;
    logic [3:0]  Ewriteaddr;
    logic        Ezero;
    logic [15:0] Ehi;
    logic [15:0] Elo;
    logic        Estall;

    modport master (
        output Erd1, Erd2, Esignextimm, Ea2, Ea3, Ealucontrol, Ealusrc, Eregwrite,
               Ehilowrite, Emultdiv, Emod, Eforwarda, Eforwardb, Mresult, Wresult,
        input  Ealuout, Ewritedata, Ewriteaddr, Ezero, Ehi, Elo, Estall
    );

    modport slave (
        input  Erd1, Erd2, Esignextimm, Ea2, Ea3, Ealucontrol, Ealusrc, Eregwrite,
               Ehilowrite, Emultdiv, Emod, Eforwarda, Eforwardb, Mresult, Wresult,
        output Ealuout, Ewritedata, Ewriteaddr, Ezero, Ehi, Elo, Estall
    );
endinterface

// File: rtl/execute_stage.sv
// Execute stage of the 16-bit core: forwarding, ALU, write-address select,
// HI/LO registers and an iterative 16-step multiply/divide unit.
module execute_stage (
    input  logic     clk,
    input  logic     reset,
    execute_if.slave bus
);
    localparam logic [4:0] OP_ADD   = 5'b00000, OP_SUB  = 5'b00001, OP_AND   = 5'b00010,
                           OP_OR    = 5'b00011, OP_XOR  = 5'b00100, OP_NOR   = 5'b00101,
                           OP_SLT   = 5'b00110, OP_SLL  = 5'b00111, OP_SRL   = 5'b01000,
                           OP_SRA   = 5'b01001, OP_PASSB = 5'b01010,
                           OP_MULT  = 5'b10000, OP_MULTU = 5'b10001, OP_DIV  = 5'b10010,
                           OP_DIVU  = 5'b10011, OP_MFHI = 5'b10100, OP_MFLO  = 5'b10101;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    function automatic logic [15:0] neg16(input logic [15:0] x);
        return ~x + 16'd1;
    endfunction

    function automatic logic [15:0] fwd_sel(input logic [1:0] sel, input logic [15:0] rd,
                                            input logic [15:0] wres, input logic [15:0] mres);
        logic [15:0] r;
        case (sel)
            2'b01:   r = wres;
            2'b10:   r = mres;
            default: r = rd;
        endcase
        return r;
    endfunction

    state_t             state, state_nxt;
    logic [3:0]         step_q;
    logic signed [15:0] srca, srcb;
    logic [15:0]        fwd_b;
    logic               is_muldiv, start, stall;
    logic               a_neg, b_neg;
    logic [15:0]        mag_a_in, mag_b_in;

    // Latched operands; work_q holds {acc, multiplier} or {remainder, quotient}
    logic [1:0]         op_q;
    logic [15:0]        raw_a_q, mag_a_q, mag_b_q;
    logic               neg_q_q, neg_r_q;
    logic [31:0]        work_q, work_step, prod;
    logic [16:0]        mul_sum, rem_sh;
    logic [15:0]        rem_sub, rem_new, quo, rem, res_hi, res_lo;
    logic               ge;
    logic [15:0]        hi_q, lo_q, alu_out;
    logic [3:0]         waddr;

    assign srca  = fwd_sel(bus.Eforwarda, bus.Erd1, bus.Wresult, bus.Mresult);
    assign fwd_b = fwd_sel(bus.Eforwardb, bus.Erd2, bus.Wresult, bus.Mresult);
    assign srcb  = bus.Ealusrc ? bus.Esignextimm : fwd_b;

    assign is_muldiv = (bus.Ealucontrol[4:2] == 3'b100);
    assign start     = (state == IDLE) && is_muldiv;

    // Signed ops run on magnitudes; signs are reapplied to the final result
    assign a_neg    = ~bus.Ealucontrol[0] & srca[15];
    assign b_neg    = ~bus.Ealucontrol[0] & srcb[15];
    assign mag_a_in = a_neg ? neg16(srca) : srca;
    assign mag_b_in = b_neg ? neg16(srcb) : srcb;

    assign mul_sum   = {1'b0, work_q[31:16]} + (work_q[0] ? {1'b0, mag_a_q} : 17'd0);
    assign rem_sh    = {work_q[31:16], work_q[15]};
    assign ge        = (rem_sh >= {1'b0, mag_b_q});
    assign rem_sub   = rem_sh[15:0] - mag_b_q;
    assign rem_new   = ge ? rem_sub : rem_sh[15:0];
    assign work_step = op_q[1] ? {rem_new, work_q[14:0], ge} : {mul_sum, work_q[15:1]};

    assign prod   = neg_q_q ? (~work_q + 32'd1) : work_q;
    assign quo    = (mag_b_q == 16'd0) ? 16'hFFFF : (neg_q_q ? neg16(work_q[15:0]) : work_q[15:0]);
    assign rem    = (mag_b_q == 16'd0) ? raw_a_q  : (neg_r_q ? neg16(work_q[31:16]) : work_q[31:16]);
    assign res_hi = op_q[1] ? rem : prod[31:16];
    assign res_lo = op_q[1] ? quo : prod[15:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            step_q <= 4'd0;
        end else begin
            state <= state_nxt;
            if (start)               step_q <= 4'd0;
            else if (state == BUSY)  step_q <= step_q + 4'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = is_muldiv ? BUSY : IDLE;
            BUSY:    state_nxt = (step_q == 4'd15) ? DONE : BUSY;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stall = 1'b0;
        case (state)
            IDLE:    stall = is_muldiv;
            BUSY:    stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (start) begin
            op_q    <= bus.Ealucontrol[1:0];
            raw_a_q <= srca;
            mag_a_q <= mag_a_in;
            mag_b_q <= mag_b_in;
            neg_q_q <= a_neg ^ b_neg;
            neg_r_q <= a_neg;
            work_q  <= bus.Ealucontrol[1] ? {16'd0, mag_a_in} : {16'd0, mag_b_in};
        end else if (state == BUSY) begin
            work_q <= work_step;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= 16'd0;
            lo_q <= 16'd0;
        end else if (state == DONE && bus.Ehilowrite && bus.Emultdiv) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
        end else if (bus.Ehilowrite && !bus.Emultdiv) begin
            hi_q <= srca;
            lo_q <= srcb;
        end
    end

    always_comb begin
        alu_out = 16'd0;
        case (bus.Ealucontrol)
            OP_ADD:   alu_out = srca + srcb;
            OP_SUB:   alu_out = srca - srcb;
            OP_AND:   alu_out = srca & srcb;
            OP_OR:    alu_out = srca | srcb;
            OP_XOR:   alu_out = srca ^ srcb;
            OP_NOR:   alu_out = ~(srca | srcb);
            OP_SLT:   alu_out = (srca < srcb) ? 16'd1 : 16'd0;
            OP_SLL:   alu_out = srca << srcb[3:0];
            OP_SRL:   alu_out = srca >> srcb[3:0];
            OP_SRA:   alu_out = srca >>> srcb[3:0];
            OP_PASSB: alu_out = srcb;
            OP_MFHI:  alu_out = hi_q;
            OP_MFLO:  alu_out = lo_q;
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU:
                if (state == DONE) alu_out = (op_q[1] && bus.Emod) ? res_hi : res_lo;
            default:  alu_out = 16'd0;
        endcase
    end

    always_comb begin
        case (bus.Eregwrite)
            2'b00:   waddr = bus.Ea2;
            2'b01:   waddr = bus.Ea3;
            2'b10:   waddr = 4'd15;
            default: waddr = 4'd0;
        endcase
    end

    assign bus.Ealuout    = alu_out;
    assign bus.Ezero      = (alu_out == 16'd0);
    assign bus.Ewritedata = fwd_b;
    assign bus.Ewriteaddr = waddr;
    assign bus.Ehi        = hi_q;
    assign bus.Elo        = lo_q;
    assign bus.Estall     = stall;
endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: vector table for single-cycle ops,
// hand sequences for mul/div corner cases, randomized runs against a reference model.
module tb_execute_stage;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    execute_if bus();
    execute_stage dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;
    logic [15:0] m_hi, m_lo;

    typedef struct {
        logic [4:0]  op;
        logic [15:0] rd1, rd2, imm, mres, wres;
        logic        alusrc;
        logic [1:0]  fwda, fwdb, regwrite;
        logic [15:0] exp_out, exp_wd;
        logic        exp_zero;
        logic [3:0]  exp_addr;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.Erd1 = 16'd0; bus.Erd2 = 16'd0; bus.Esignextimm = 16'd0;
        bus.Ea2 = 4'h3; bus.Ea3 = 4'h9;
        bus.Ealucontrol = 5'b00000; bus.Ealusrc = 1'b0; bus.Eregwrite = 2'b00;
        bus.Ehilowrite = 1'b0; bus.Emultdiv = 1'b0; bus.Emod = 1'b0;
        bus.Eforwarda = 2'b00; bus.Eforwardb = 2'b00;
        bus.Mresult = 16'd0; bus.Wresult = 16'd0;
    endtask

    function automatic logic [15:0] fwd_ref(input logic [1:0] sel, input logic [15:0] rd,
                                            input logic [15:0] m, input logic [15:0] w);
        if (sel == 2'b01) return w;
        if (sel == 2'b10) return m;
        return rd;
    endfunction

    function automatic logic [15:0] alu_ref(input logic [4:0] op, input logic [15:0] a,
                                            input logic [15:0] b, input logic [15:0] hi,
                                            input logic [15:0] lo);
        logic signed [15:0] sa, sb;
        sa = a; sb = b;
        case (op)
            5'd0:    return a + b;
            5'd1:    return a - b;
            5'd2:    return a & b;
            5'd3:    return a | b;
            5'd4:    return a ^ b;
            5'd5:    return ~(a | b);
            5'd6:    return (sa < sb) ? 16'd1 : 16'd0;
            5'd7:    return a << b[3:0];
            5'd8:    return a >> b[3:0];
            5'd9:    return sa >>> b[3:0];
            5'd10:   return b;
            5'd20:   return hi;
            5'd21:   return lo;
            default: return 16'd0;
        endcase
    endfunction

    // Returns {HI, LO} computed with plain wide integer arithmetic
    function automatic logic [31:0] muldiv_ref(input logic [4:0] op, input logic [15:0] a,
                                               input logic [15:0] b);
        logic signed [15:0] s16a, s16b;
        longint sa, sb, ua, ub, p, q, r;
        s16a = a; s16b = b;
        sa = s16a; sb = s16b;
        ua = {48'd0, a}; ub = {48'd0, b};
        case (op)
            5'd16: begin p = sa * sb; return p[31:0]; end
            5'd17: begin p = ua * ub; return p[31:0]; end
            5'd18: begin
                if (b == 16'd0) return {a, 16'hFFFF};
                q = sa / sb; r = sa % sb;
                return {r[15:0], q[15:0]};
            end
            default: begin
                if (b == 16'd0) return {a, 16'hFFFF};
                q = ua / ub; r = ua % ub;
                return {r[15:0], q[15:0]};
            end
        endcase
    endfunction

    // Presents a mul/div op, counts stall cycles and checks the DONE result.
    // Returns in the DONE cycle with the op still presented.
    task automatic run_md(input string name, input logic [4:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic mod, input logic [15:0] exp_out,
                          input bit perturb);
        int n;
        n = 0;
        bus.Ealucontrol = op; bus.Erd1 = a; bus.Erd2 = b; bus.Ealusrc = 1'b0;
        bus.Eforwarda = 2'b00; bus.Eforwardb = 2'b00; bus.Emod = mod;
        bus.Ehilowrite = 1'b1; bus.Emultdiv = 1'b1;
        if (perturb) begin
            bus.Eforwarda = 2'b10; bus.Mresult = a; bus.Erd1 = ~a;
        end
        #1;
        while (bus.Estall === 1'b1 && n < 40) begin
            if (perturb && n == 6) begin
                bus.Mresult = 16'($urandom);
                bus.Erd2 = 16'($urandom);
            end
            tick();
            n++;
        end
        chk({name, " stall_cycles"}, n, 17);
        chk({name, " aluout"}, bus.Ealuout, exp_out);
    endtask

    task automatic chk_hilo(input string name, input logic [15:0] hi, input logic [15:0] lo);
        chk({name, " hi"}, bus.Ehi, hi);
        chk({name, " lo"}, bus.Elo, lo);
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("reset stall", bus.Estall, 0);
        chk_hilo("reset", 16'h0000, 16'h0000);

        // op, rd1, rd2, imm, mres, wres, alusrc, fwda, fwdb, regwrite, out, wd, zero, addr
        vecs[0]  = '{5'd0,  16'h7FFF, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 1'b0, 2'b00, 2'b00, 2'b00, 16'h8000, 16'h0001, 1'b0, 4'h3};
        vecs[1]  = '{5'd6,  16'h8000, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 1'b0, 2'b00, 2'b00, 2'b01, 16'h0001, 16'h0001, 1'b0, 4'h9};
        vecs[2]  = '{5'd9,  16'h8000, 16'h0003, 16'h0000, 16'h0000, 16'h0000, 1'b0, 2'b00, 2'b00, 2'b00, 16'hF000, 16'h0003, 1'b0, 4'h3};
        vecs[3]  = '{5'd0,  16'h1111, 16'h2222, 16'h0005, 16'h0010, 16'h0000, 1'b1, 2'b10, 2'b00, 2'b10, 16'h0015, 16'h2222, 1'b0, 4'hF};
        vecs[4]  = '{5'd1,  16'h1234, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 1'b0, 2'b00, 2'b00, 2'b11, 16'h0000, 16'h1234, 1'b1, 4'h0};
        vecs[5]  = '{5'd2,  16'hFF00, 16'h0000, 16'h0000, 16'h0000, 16'h0F0F, 1'b0, 2'b00, 2'b01, 2'b00, 16'h0F00, 16'h0F0F, 1'b0, 4'h3};
        vecs[6]  = '{5'd3,  16'h00F0, 16'h0000, 16'h0000, 16'h0F00, 16'h0000, 1'b0, 2'b00, 2'b10, 2'b00, 16'h0FF0, 16'h0F00, 1'b0, 4'h3};
        vecs[7]  = '{5'd4,  16'hAAAA, 16'hFFFF, 16'h0000, 16'h1234, 16'h5678, 1'b0, 2'b11, 2'b11, 2'b00, 16'h5555, 16'hFFFF, 1'b0, 4'h3};
        vecs[8]  = '{5'd5,  16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 2'b00, 2'b00, 2'b00, 16'hFFFF, 16'h0000, 1'b0, 4'h3};
        vecs[9]  = '{5'd7,  16'h0001, 16'h0014, 16'h0000, 16'h0000, 16'h0000, 1'b0, 2'b00, 2'b00, 2'b00, 16'h0010, 16'h0014, 1'b0, 4'h3};
        vecs[10] = '{5'd8,  16'h8000, 16'h000F, 16'h0000, 16'h0000, 16'h0000, 1'b0, 2'b00, 2'b00, 2'b00, 16'h0001, 16'h000F, 1'b0, 4'h3};
        vecs[11] = '{5'd10, 16'h0001, 16'h0002, 16'hBEEF, 16'h0000, 16'h0000, 1'b1, 2'b00, 2'b00, 2'b00, 16'hBEEF, 16'h0002, 1'b0, 4'h3};
        vecs[12] = '{5'd11, 16'h1234, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 1'b0, 2'b00, 2'b00, 2'b00, 16'h0000, 16'h0001, 1'b1, 4'h3};
        vecs[13] = '{5'd31, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 1'b0, 2'b00, 2'b00, 2'b00, 16'h0000, 16'hFFFF, 1'b1, 4'h3};
        vecs[14] = '{5'd6,  16'h0001, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 2'b00, 2'b00, 2'b00, 16'h0000, 16'h8000, 1'b1, 4'h3};

        for (int i = 0; i < 15; i++) begin
            bus.Ealucontrol = vecs[i].op; bus.Erd1 = vecs[i].rd1; bus.Erd2 = vecs[i].rd2;
            bus.Esignextimm = vecs[i].imm; bus.Mresult = vecs[i].mres; bus.Wresult = vecs[i].wres;
            bus.Ealusrc = vecs[i].alusrc; bus.Eforwarda = vecs[i].fwda;
            bus.Eforwardb = vecs[i].fwdb; bus.Eregwrite = vecs[i].regwrite;
            #1;
            chk($sformatf("vec%0d aluout", i), bus.Ealuout, vecs[i].exp_out);
            chk($sformatf("vec%0d writedata", i), bus.Ewritedata, vecs[i].exp_wd);
            chk($sformatf("vec%0d zero", i), bus.Ezero, vecs[i].exp_zero);
            chk($sformatf("vec%0d writeaddr", i), bus.Ewriteaddr, vecs[i].exp_addr);
            chk($sformatf("vec%0d stall", i), bus.Estall, 0);
            tick();
        end
        idle_inputs();

        run_md("mult_fwd", 5'd16, 16'hFFFE, 16'h0003, 1'b0, 16'hFFFA, 1'b1);
        tick(); idle_inputs(); #1;
        chk_hilo("mult_fwd", 16'hFFFF, 16'hFFFA);

        run_md("divu_q", 5'd19, 16'd100, 16'd7, 1'b0, 16'h000E, 1'b0);
        tick(); idle_inputs(); #1;
        chk_hilo("divu_q", 16'h0002, 16'h000E);

        run_md("divu_r", 5'd19, 16'd100, 16'd7, 1'b1, 16'h0002, 1'b0);
        tick(); idle_inputs(); #1;
        chk_hilo("divu_r", 16'h0002, 16'h000E);

        run_md("div_by0", 5'd18, 16'h1234, 16'h0000, 1'b0, 16'hFFFF, 1'b0);
        tick(); idle_inputs(); #1;
        chk_hilo("div_by0", 16'h1234, 16'hFFFF);

        run_md("div_ovf", 5'd18, 16'h8000, 16'hFFFF, 1'b0, 16'h8000, 1'b0);
        tick(); idle_inputs(); #1;
        chk_hilo("div_ovf", 16'h0000, 16'h8000);

        run_md("div_neg", 5'd18, 16'hFFF9, 16'h0002, 1'b1, 16'hFFFF, 1'b0);
        tick(); idle_inputs();
        bus.Ealucontrol = 5'd20; #1;
        chk("mfhi after div", bus.Ealuout, 16'hFFFF);
        tick();
        bus.Ealucontrol = 5'd21; #1;
        chk("mflo after div", bus.Ealuout, 16'hFFFD);
        tick();

        // Move-to writes immediately; mul/div-sourced write on a plain op is ignored
        idle_inputs();
        bus.Erd1 = 16'h1111; bus.Erd2 = 16'h2222; bus.Ehilowrite = 1'b1; bus.Emultdiv = 1'b0;
        tick();
        idle_inputs(); #1;
        chk_hilo("move_to", 16'h1111, 16'h2222);
        bus.Erd1 = 16'h5555; bus.Erd2 = 16'h6666; bus.Ehilowrite = 1'b1; bus.Emultdiv = 1'b1;
        tick();
        idle_inputs(); #1;
        chk_hilo("no_write", 16'h1111, 16'h2222);

        // MULTU then DIVU back to back, DIVU aborted by reset in BUSY
        run_md("multu_max", 5'd17, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 1'b0);
        tick();
        bus.Ealucontrol = 5'd19; bus.Erd1 = 16'h9999; bus.Erd2 = 16'h0003; bus.Emod = 1'b0;
        #1;
        chk_hilo("multu_max", 16'hFFFE, 16'h0001);
        chk("b2b divu stall", bus.Estall, 1);
        for (int i = 0; i < 5; i++) tick();
        chk("divu busy stall", bus.Estall, 1);
        reset = 1'b1;
        idle_inputs();
        tick();
        reset = 1'b0;
        #1;
        chk("abort stall", bus.Estall, 0);
        chk_hilo("abort", 16'h0000, 16'h0000);

        // Randomized phase against the reference model
        bus.Erd1 = 16'hA5A5; bus.Erd2 = 16'h5A5A; bus.Ehilowrite = 1'b1; bus.Emultdiv = 1'b0;
        tick();
        m_hi = 16'hA5A5; m_lo = 16'h5A5A;
        idle_inputs();
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                logic [4:0]  op;
                logic [15:0] a, b, eo;
                logic [31:0] ref_hl;
                logic        mod;
                op = 5'd16 + 5'($urandom_range(0, 3));
                a = 16'($urandom); b = 16'($urandom);
                if ($urandom_range(0, 7) == 0) b = 16'd0;
                if ($urandom_range(0, 7) == 0) b = 16'($urandom_range(1, 9));
                mod = 1'($urandom);
                ref_hl = muldiv_ref(op, a, b);
                eo = (op[1] && mod) ? ref_hl[31:16] : ref_hl[15:0];
                run_md($sformatf("rnd%0d op%0d", it, op), op, a, b, mod, eo, 1'($urandom));
                tick(); idle_inputs(); #1;
                m_hi = ref_hl[31:16]; m_lo = ref_hl[15:0];
                chk_hilo($sformatf("rnd%0d", it), m_hi, m_lo);
            end else begin
                logic [4:0]  op;
                logic [15:0] sa, sb, fb;
                op = 5'($urandom_range(0, 31));
                if (op >= 5'd16 && op <= 5'd19) op = 5'd20 + 5'(op[0]);
                bus.Ealucontrol = op;
                bus.Erd1 = 16'($urandom); bus.Erd2 = 16'($urandom); bus.Esignextimm = 16'($urandom);
                bus.Mresult = 16'($urandom); bus.Wresult = 16'($urandom);
                bus.Ealusrc = 1'($urandom); bus.Eforwarda = 2'($urandom); bus.Eforwardb = 2'($urandom);
                bus.Eregwrite = 2'($urandom);
                bus.Ea2 = 4'($urandom); bus.Ea3 = 4'($urandom);
                #1;
                sa = fwd_ref(bus.Eforwarda, bus.Erd1, bus.Mresult, bus.Wresult);
                fb = fwd_ref(bus.Eforwardb, bus.Erd2, bus.Mresult, bus.Wresult);
                sb = bus.Ealusrc ? bus.Esignextimm : fb;
                chk($sformatf("rnd%0d op%0d aluout", it, op), bus.Ealuout, alu_ref(op, sa, sb, m_hi, m_lo));
                chk($sformatf("rnd%0d zero", it), bus.Ezero, alu_ref(op, sa, sb, m_hi, m_lo) == 16'd0);
                chk($sformatf("rnd%0d writedata", it), bus.Ewritedata, fb);
                chk($sformatf("rnd%0d writeaddr", it), bus.Ewriteaddr,
                    (bus.Eregwrite == 2'b00) ? bus.Ea2 : (bus.Eregwrite == 2'b01) ? bus.Ea3 :
                    (bus.Eregwrite == 2'b10) ? 4'd15 : 4'd0);
                tick();
                idle_inputs();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
